// File: rtl/anemometer_pulse_gen.sv
// Synthetic anemometer: emits N evenly spaced rotation pulses per gate window,
// N = round(speed_kmh * 278 / 408) clipped to MAX_COUNT, plus a gate strobe per window.
module anemometer_pulse_gen #(
    parameter int GATE_CYCLES = 50000000,
    parameter int PULSE_HIGH  = 1000,
    parameter int MAX_COUNT   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] speed,
    output logic       rotation,
    output logic       gate_tick,
    output logic [3:0] window_count,
    output logic [6:0] active_speed,
    output logic       saturated
);

    localparam int CW = $clog2(GATE_CYCLES);
    localparam int AW = CW + 1;
    localparam int HW = $clog2(PULSE_HIGH + 1);

    localparam logic [AW-1:0] GC_A   = AW'(GATE_CYCLES);
    localparam logic [AW-1:0] HALF_A = AW'(GATE_CYCLES / 2);
    localparam logic [CW-1:0] LAST_C = CW'(GATE_CYCLES - 1);
    localparam logic [HW-1:0] HIGH_R = HW'(PULSE_HIGH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          r_state,  w_state_nxt;
    logic [AW-1:0]   r_acc,    w_acc_nxt;
    logic [CW-1:0]   r_cnt,    w_cnt_nxt;
    logic [3:0]      r_pulses, w_pulses_nxt;
    logic [HW-1:0]   r_high,   w_high_nxt;
    logic [3:0]      r_n,      w_n_nxt;
    logic            r_rot,    w_rot_nxt;
    logic            r_gate,   w_gate_nxt;
    logic [3:0]      r_wc,     w_wc_nxt;
    logic [6:0]      r_speed,  w_speed_nxt;
    logic            r_sat,    w_sat_nxt;

    logic [15:0]     w_prod;
    logic [15:0]     w_quot;
    logic            w_sat;
    logic [3:0]      w_n;
    logic [AW-1:0]   w_sum;

    // +204 is half of 408, turning the floor division into round-to-nearest
    always_comb begin
        w_prod = {9'd0, speed} * 16'd278 + 16'd204;
        w_quot = w_prod / 16'd408;
        w_sat  = (w_quot > 16'(MAX_COUNT));
        w_n    = w_sat ? 4'(MAX_COUNT) : w_quot[3:0];
        w_sum  = r_acc + AW'(r_n);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_pulses_nxt = r_pulses;
        w_high_nxt   = r_high;
        w_n_nxt      = r_n;
        w_rot_nxt    = r_rot;
        w_gate_nxt   = 1'b0;
        w_wc_nxt     = r_wc;
        w_speed_nxt  = r_speed;
        w_sat_nxt    = r_sat;

        case (r_state)
            IDLE: begin
                w_rot_nxt  = 1'b0;
                w_high_nxt = '0;
                if (enable) begin
                    w_state_nxt  = RUN;
                    w_speed_nxt  = speed;
                    w_n_nxt      = w_n;
                    w_sat_nxt    = w_sat;
                    w_acc_nxt    = HALF_A;
                    w_cnt_nxt    = '0;
                    w_pulses_nxt = '0;
                    w_gate_nxt   = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                    w_rot_nxt   = 1'b0;
                    w_high_nxt  = '0;
                end else begin
                    if (r_rot) begin
                        if (r_high == '0) w_rot_nxt = 1'b0;
                        else              w_high_nxt = r_high - HW'(1);
                    end
                    // The phase seed keeps the final crossing clear of the last cycle,
                    // so the boundary cycle never needs to start a pulse.
                    if (r_cnt == LAST_C) begin
                        w_gate_nxt   = 1'b1;
                        w_wc_nxt     = r_pulses;
                        w_pulses_nxt = '0;
                        w_cnt_nxt    = '0;
                        w_acc_nxt    = HALF_A;
                        w_speed_nxt  = speed;
                        w_n_nxt      = w_n;
                        w_sat_nxt    = w_sat;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                        if (w_sum >= GC_A) begin
                            w_acc_nxt    = w_sum - GC_A;
                            w_rot_nxt    = 1'b1;
                            w_high_nxt   = HIGH_R;
                            w_pulses_nxt = r_pulses + 4'd1;
                        end else begin
                            w_acc_nxt = w_sum;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_pulses <= '0;
            r_high   <= '0;
            r_n      <= '0;
            r_rot    <= 1'b0;
            r_gate   <= 1'b0;
            r_wc     <= '0;
            r_speed  <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pulses <= w_pulses_nxt;
            r_high   <= w_high_nxt;
            r_n      <= w_n_nxt;
            r_rot    <= w_rot_nxt;
            r_gate   <= w_gate_nxt;
            r_wc     <= w_wc_nxt;
            r_speed  <= w_speed_nxt;
            r_sat    <= w_sat_nxt;
        end
    end

    assign rotation     = r_rot;
    assign gate_tick    = r_gate;
    assign window_count = r_wc;
    assign active_speed = r_speed;
    assign saturated    = r_sat;

endmodule
